mem_entry_writer: RTL and testbench

- Manual data-entry path for the DE2 processor lab: the write-side counterpart of the HEX readout path.
- The operator sets an address byte and two data bytes on switches, then commits with a push-button. Each press is synchronised, debounced and edge-detected.
- On commit, the block issues a req/ack write to the processor's data memory and can auto-advance the address.
- Sits between the board switches/KEY and the memory write port. Its WrAddr/WrData outputs also feed the display mux.

---
 rtl/mem_entry_pkg.sv | 18 +
 rtl/mem_entry_writer_key_conditioner.sv | 55 +++++
 rtl/mem_entry_writer.sv | 105 ++++++++++
 tb/tb_mem_entry_writer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_entry_pkg.sv
// Shared types for the manual memory-entry path: FSM state encoding and the
// meaning of the two Field switches.
package mem_entry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FLD_ADDR   = 2'd0;
    localparam logic [1:0] FLD_HI     = 2'd1;
    localparam logic [1:0] FLD_LO     = 2'd2;
    localparam logic [1:0] FLD_COMMIT = 2'd3;

    localparam int DATA_W = 16;

endpackage

// File: rtl/mem_entry_writer_key_conditioner.sv
// Push-button conditioning: 2-flop synchroniser, debounce counter and a
// single-cycle press pulse on the released->pressed transition.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic KeyN,
    output logic Press,
    output logic Level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    // The key is inverted before synchronising so every flop clears to "released".
    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], ~KeyN};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end

    assign Press = press_q;
    assign Level = level_q;

endmodule

// File: rtl/mem_entry_writer.sv
// Switch/KEY driven data-entry path that issues req/ack writes to data memory.
// Optional AUTO_INC_EN: advance WrAddr after each completed write.
module mem_entry_writer
    import mem_entry_pkg::*;
#(
    parameter int ADDR_W          = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              KeyN,
    input  logic [1:0]        Field,
    input  logic [7:0]        Sw,
    output logic              WrReq,
    input  logic              WrAck,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData,
    output logic              Busy,
    output logic [CNT_W-1:0]  WrCount,
    output logic              Dropped,
    output state_t            DbgState
);

    // Handshake: WrReq rises the edge after a commit and stays high until an
    // edge samples WrAck=1; it drops on that same edge. WrAck is ignored otherwise.

    logic press;
    logic level;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .Clock(Clock),
        .Reset(Reset),
        .KeyN (KeyN),
        .Press(press),
        .Level(level)
    );

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dropped_q, dropped_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        dropped_d = dropped_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    case (Field)
                        FLD_ADDR:   addr_d       = Sw[ADDR_W-1:0];
                        FLD_HI:     data_d[15:8] = Sw;
                        FLD_LO:     data_d[7:0]  = Sw;
                        FLD_COMMIT: state_d      = REQ;
                        default:    state_d      = IDLE;
                    endcase
                end
            end
            REQ: begin
                if (press) dropped_d = 1'b1;
                if (WrAck) state_d = DONE;
            end
            DONE: begin
                if (press) dropped_d = 1'b1;
                cnt_d = cnt_q + 1'b1;
`ifdef AUTO_INC_EN
                addr_d = addr_q + 1'b1;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
        end
    end

    assign WrReq    = (state_q == REQ);
    assign Busy     = (state_q == REQ) || (state_q == DONE);
    assign WrAddr   = addr_q;
    assign WrData   = data_q;
    assign WrCount  = cnt_q;
    assign Dropped  = dropped_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_mem_entry_writer.sv
// Self-checking bench for mem_entry_writer with a short debounce window.
module tb_mem_entry_writer;
    import mem_entry_pkg::*;

    localparam int D = 4;

    logic        Clock;
    logic        Reset;
    logic        KeyN;
    logic [1:0]  Field;
    logic [7:0]  Sw;
    logic        WrReq;
    logic        WrAck;
    logic [7:0]  WrAddr;
    logic [15:0] WrData;
    logic        Busy;
    logic [7:0]  WrCount;
    logic        Dropped;
    state_t      DbgState;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    logic [7:0]  m_cnt;

    mem_entry_writer #(
        .ADDR_W(8),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(8)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .KeyN    (KeyN),
        .Field   (Field),
        .Sw      (Sw),
        .WrReq   (WrReq),
        .WrAck   (WrAck),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .Busy    (Busy),
        .WrCount (WrCount),
        .Dropped (Dropped),
        .DbgState(DbgState)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [1:0] fld, input logic [7:0] sw);
        Field = fld;
        Sw    = sw;
        KeyN  = 1'b0;
        repeat (D + 6) @(negedge Clock);
        KeyN = 1'b1;
        repeat (D + 6) @(negedge Clock);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!WrReq && n < 50) begin
            @(negedge Clock);
            n++;
        end
        ok = WrReq;
        if (!ok) check("req_timeout", 32'(WrReq), 32'd1);
    endtask

    task automatic sb_compare();
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_addr", 32'(WrAddr), 32'(e[23:16]));
            check("sb_data", 32'(WrData), 32'(e[15:0]));
        end
    endtask

    task automatic model_done();
        m_cnt = m_cnt + 8'd1;
`ifdef AUTO_INC_EN
        m_addr = m_addr + 8'd1;
`endif
    endtask

    // commit press, ack lat cycles after WrReq rises, then release the key
    task automatic commit(input int lat);
        bit ok;
        int req_len;
        exp_q.push_back({m_addr, m_data});
        Field = FLD_COMMIT;
        KeyN  = 1'b0;
        wait_req(ok);
        req_len = 0;
        while (ok && WrReq && req_len < 100) begin
            req_len++;
            if (req_len == lat) begin
                sb_compare();
                WrAck = 1'b1;
            end
            @(negedge Clock);
            WrAck = 1'b0;
        end
        check("req_len", 32'(req_len), 32'(lat));
        check("busy_done", 32'(Busy), 32'd1);
        @(negedge Clock);
        check("busy_idle", 32'(Busy), 32'd0);
        model_done();
        check("count", 32'(WrCount), 32'(m_cnt));
        check("addr_after", 32'(WrAddr), 32'(m_addr));
        KeyN = 1'b1;
        repeat (D + 6) @(negedge Clock);
    endtask

    task automatic bounce_test();
        int cyc = 0;
        int pulses = 0;
        int first = 0;
        Field = FLD_ADDR;
        Sw    = 8'h5A;
        for (int t = 0; t < 3; t++) begin
            KeyN = 1'b0;
            repeat (2) begin @(negedge Clock); if (dut.u_key.Press) pulses++; end
            KeyN = 1'b1;
            repeat (2) begin @(negedge Clock); if (dut.u_key.Press) pulses++; end
        end
        KeyN = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clock);
            if (dut.u_key.Press) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("press_latency", 32'(first), 32'd7);
        for (int t = 0; t < 3; t++) begin
            KeyN = 1'b1;
            repeat (2) begin @(negedge Clock); if (dut.u_key.Press) pulses++; end
            KeyN = 1'b0;
            repeat (2) begin @(negedge Clock); if (dut.u_key.Press) pulses++; end
        end
        KeyN = 1'b1;
        repeat (12) begin @(negedge Clock); cyc++; if (dut.u_key.Press) pulses++; end
        check("press_pulses", 32'(pulses), 32'd1);
        m_addr = 8'h5A;
        check("bounce_addr", 32'(WrAddr), 32'(m_addr));
        check("bounce_level", 32'(dut.u_key.Level), 32'd0);
    endtask

    initial begin
        bit ok;
        Reset  = 1'b1;
        KeyN   = 1'b1;
        Field  = 2'd0;
        Sw     = 8'h00;
        WrAck  = 1'b0;
        m_addr = 8'h00;
        m_data = 16'h0000;
        m_cnt  = 8'h00;
        repeat (3) @(negedge Clock);
        check("rst_req", 32'(WrReq), 32'd0);
        check("rst_addr", 32'(WrAddr), 32'd0);
        check("rst_data", 32'(WrData), 32'd0);
        check("rst_count", 32'(WrCount), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_dropped", 32'(Dropped), 32'd0);
        check("rst_state", 32'(DbgState), 32'(IDLE));
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // 1: basic entry and commit
        press(FLD_ADDR, 8'h12);
        press(FLD_HI, 8'hAB);
        press(FLD_LO, 8'hCD);
        m_addr = 8'h12;
        m_data = 16'hABCD;
        check("entry_addr", 32'(WrAddr), 32'h12);
        check("entry_data", 32'(WrData), 32'hABCD);
        commit(3);
        check("t1_count", 32'(WrCount), 32'd1);

        // 2: bounce filtering
        bounce_test();

        // 3: press while busy is dropped
        exp_q.push_back({m_addr, m_data});
        Field = FLD_COMMIT;
        KeyN  = 1'b0;
        wait_req(ok);
        KeyN = 1'b1;
        repeat (D + 6) @(negedge Clock);
        press(FLD_HI, 8'hFF);
        check("drop_req_held", 32'(WrReq), 32'd1);
        check("drop_data", 32'(WrData), 32'(m_data));
        check("drop_flag", 32'(Dropped), 32'd1);
        sb_compare();
        WrAck = 1'b1;
        @(negedge Clock);
        WrAck = 1'b0;
        @(negedge Clock);
        model_done();
        check("drop_count", 32'(WrCount), 32'(m_cnt));
        check("drop_sticky", 32'(Dropped), 32'd1);

        // 4: reset in the middle of a request
        exp_q.push_back({m_addr, m_data});
        Field = FLD_COMMIT;
        KeyN  = 1'b0;
        wait_req(ok);
        #2 Reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(WrReq), 32'd0);
        check("rst_mid_count", 32'(WrCount), 32'd0);
        check("rst_mid_addr", 32'(WrAddr), 32'd0);
        check("rst_mid_dropped", 32'(Dropped), 32'd0);
        check("rst_mid_state", 32'(DbgState), 32'(IDLE));
        exp_q.delete();
        m_addr = 8'h00;
        m_data = 16'h0000;
        m_cnt  = 8'h00;
        KeyN = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        WrAck = 1'b1;
        @(negedge Clock);
        WrAck = 1'b0;
        @(negedge Clock);
        check("stray_ack_count", 32'(WrCount), 32'd0);
        check("stray_ack_state", 32'(DbgState), 32'(IDLE));

        // 5: address wrap on commit
        press(FLD_ADDR, 8'hFF);
        m_addr = 8'hFF;
        commit(2);
`ifdef AUTO_INC_EN
        check("auto_inc_wrap", 32'(WrAddr), 32'h00);
`else
        check("no_auto_inc", 32'(WrAddr), 32'hFF);
`endif

        // 6: counter wrap and idle ack
        for (int i = 0; i < 254; i++) commit(1);
        check("count_ff", 32'(WrCount), 32'hFF);
        commit(1);
        check("count_wrap", 32'(WrCount), 32'h00);
        WrAck = 1'b1;
        @(negedge Clock);
        WrAck = 1'b0;
        repeat (2) @(negedge Clock);
        check("idle_ack_count", 32'(WrCount), 32'h00);
        check("idle_ack_req", 32'(WrReq), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
